if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter PC_ADDR, default 32'h8000_0000, meaning the fetch address after reset.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning the PC and bus address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning the instruction and bus data width.
REQ-004 SHALL have clk  input  1  the single clock for the block.
REQ-005 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have redirect_valid_in  input  1  load redirect_pc_in as the next fetch PC (branch/jump target).
REQ-007 SHALL have redirect_pc_in  input  ADDR_WIDTH  redirect target address.
REQ-008 SHALL have inst_valid_out  output  1  inst_out/pc_out hold a fetched instruction.
REQ-009 SHALL have inst_ready_in  input  1  decode accepts the instruction.
REQ-010 SHALL have inst_out  output  DATA_WIDTH  fetched instruction word.
REQ-011 SHALL have pc_out  output  ADDR_WIDTH  address of inst_out.
REQ-012 SHALL have wb_cyc_o, wb_stb_o  output  1 each  Wishbone classic read request.
REQ-013 SHALL have wb_ack_i  input  1  Wishbone acknowledge.
REQ-014 SHALL have wb_adr_o  output  ADDR_WIDTH  fetch address.
REQ-015 SHALL have wb_dat_i  input  DATA_WIDTH  read data.
REQ-016 SHALL have wb_we_o  output  1 (constant 0), and wb_sel_o  output  DATA_WIDTH/8 (all ones).

Function
REQ-017 SHALL implement states IDLE, FETCH, HOLD, DISCARD; all outputs registered.
REQ-018 SHALL go IDLE->FETCH on the first clock edge after reset release, with wb_adr_o=PC_ADDR.
REQ-019 SHALL, in FETCH and DISCARD, assert wb_cyc_o=wb_stb_o=1 and keep wb_adr_o stable until wb_ack_i=1.
REQ-020 SHALL force wb_adr_o[1:0]=2'b00 regardless of the PC value.
REQ-021 SHALL, on the FETCH edge with wb_ack_i=1 and no redirect: latch inst_out=wb_dat_i and pc_out=PC, set inst_valid_out=1, set PC=PC+4 (modulo 2^ADDR_WIDTH, wrap silently), drop cyc/stb, and enter HOLD.
REQ-022 SHALL, in HOLD, keep inst_out/pc_out/inst_valid_out stable until inst_ready_in=1; on that edge clear inst_valid_out and enter FETCH at the current PC.
REQ-023 SHALL, on redirect_valid_in=1 in any state, set PC=redirect_pc_in and clear inst_valid_out on the same edge.
REQ-024 SHALL, on redirect in FETCH with wb_ack_i=0, enter DISCARD; the in-flight read completes and its data is dropped; DISCARD->FETCH on ack.
REQ-025 SHALL, on redirect in FETCH with wb_ack_i=1 in the same cycle, drop the data and enter FETCH at the redirect PC.
REQ-026 SHALL, on redirect in HOLD with inst_ready_in=1 in the same cycle, count the handshake as completed and still apply the redirect.
REQ-027 SHALL, when a new redirect arrives in DISCARD, overwrite the pending PC; the last redirect wins.
REQ-028 SHALL give a minimum throughput of one instruction per 3 cycles with a 1-cycle-ack slave and inst_ready_in held at 1.

Reset
REQ-029 SHALL, while rst_n=0, set state=IDLE, PC=PC_ADDR, inst_valid_out=0, inst_out=0, pc_out=0, wb_cyc_o=wb_stb_o=0, and wb_adr_o=0.
REQ-030 SHALL, on reset assertion mid-bus-cycle, drop cyc/stb immediately and discard any pending ack.

Structure
REQ-031 SHALL place the fetch_state_t enum, the default PC_ADDR, and INSN_BYTES=4 in the shared CPU package.
REQ-032 SHALL be a single module with no sub-module; the next-PC increment is computed inline.

Verification
REQ-033 SHALL cover reset release with a 1-cycle-ack slave returning 32'h0000_0013: first stb at 0x8000_0000, then inst_valid_out=1 with pc_out=0x8000_0000 and next fetch at 0x8000_0004.
REQ-034 SHALL cover backpressure with inst_ready_in=0 for 5 cycles: outputs stable, no bus cycle; ready=1 -> next stb at PC+4.
REQ-035 SHALL cover a redirect to 0x8000_0100 during FETCH with a 3-cycle ack delay: the old data is never valid, and the next stb is at 0x8000_0100.
REQ-036 SHALL cover a redirect coincident with ack: the data is dropped, and the following fetch is at the redirect target with no DISCARD cycle.
REQ-037 SHALL cover two redirects (0x100, then 0x200) inside DISCARD: the fetch issues at 0x8000_0200.
REQ-038 SHALL cover rst_n asserted mid-FETCH: cyc/stb=0 immediately, and after release the fetch restarts at 0x8000_0000.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared CPU package: fetch FSM encoding, reset fetch address and instruction size.
package if_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      FETCH   = 2'b01,
      HOLD    = 2'b10,
      DISCARD = 2'b11
   } fetch_state_t;

   localparam logic [31:0] PC_ADDR_DEFAULT = 32'h8000_0000;
   localparam int unsigned INSN_BYTES      = 4;

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch unit: Wishbone classic read master feeding a
// valid/ready instruction handshake, with branch/jump redirect support.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = ADDR_WIDTH'(PC_ADDR_DEFAULT)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    redirect_valid_in,
   input  logic [ADDR_WIDTH-1:0]   redirect_pc_in,
   output logic                    inst_valid_out,
   input  logic                    inst_ready_in,
   output logic [DATA_WIDTH-1:0]   inst_out,
   output logic [ADDR_WIDTH-1:0]   pc_out,
   output logic                    wb_cyc_o,
   output logic                    wb_stb_o,
   input  logic                    wb_ack_i,
   output logic [ADDR_WIDTH-1:0]   wb_adr_o,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   output logic                    wb_we_o,
   output logic [DATA_WIDTH/8-1:0] wb_sel_o
);

   fetch_state_t          state_r;
   logic [ADDR_WIDTH-1:0] pc_r;
   logic [ADDR_WIDTH-1:0] adr_r;
   logic [ADDR_WIDTH-1:0] pc_out_r;
   logic [DATA_WIDTH-1:0] inst_r;
   logic                  inst_valid_r;
   logic                  cyc_r;

   // The bus is word-addressed: the low two address bits never leave the block.
   function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] a);
      return {a[ADDR_WIDTH-1:2], 2'b00};
   endfunction

   // Fetch FSM: PC tracking, bus request and instruction hand-off in one register stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         pc_r         <= PC_ADDR;
         adr_r        <= '0;
         pc_out_r     <= '0;
         inst_r       <= '0;
         inst_valid_r <= 1'b0;
         cyc_r        <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               state_r      <= FETCH;
               cyc_r        <= 1'b1;
               inst_valid_r <= 1'b0;
               if (redirect_valid_in) begin
                  pc_r  <= redirect_pc_in;
                  adr_r <= word_addr(redirect_pc_in);
               end else begin
                  adr_r <= word_addr(pc_r);
               end
            end
            FETCH: begin
               if (redirect_valid_in) begin
                  pc_r         <= redirect_pc_in;
                  inst_valid_r <= 1'b0;
                  if (wb_ack_i) begin
                     // Read finished this cycle: drop it and start the target fetch now.
                     adr_r   <= word_addr(redirect_pc_in);
                     state_r <= FETCH;
                  end else begin
                     // Read still in flight: let it finish, then throw its data away.
                     state_r <= DISCARD;
                  end
               end else if (wb_ack_i) begin
                  inst_r       <= wb_dat_i;
                  pc_out_r     <= pc_r;
                  inst_valid_r <= 1'b1;
                  pc_r         <= pc_r + ADDR_WIDTH'(INSN_BYTES);
                  cyc_r        <= 1'b0;
                  state_r      <= HOLD;
               end else begin
                  state_r <= FETCH;
               end
            end
            HOLD: begin
               if (redirect_valid_in) begin
                  // A coincident ready still completes the handshake; the redirect wins the PC.
                  pc_r         <= redirect_pc_in;
                  inst_valid_r <= 1'b0;
                  adr_r        <= word_addr(redirect_pc_in);
                  cyc_r        <= 1'b1;
                  state_r      <= FETCH;
               end else if (inst_ready_in) begin
                  inst_valid_r <= 1'b0;
                  adr_r        <= word_addr(pc_r);
                  cyc_r        <= 1'b1;
                  state_r      <= FETCH;
               end else begin
                  state_r <= HOLD;
               end
            end
            DISCARD: begin
               if (redirect_valid_in) begin
                  pc_r <= redirect_pc_in;
               end else begin
                  pc_r <= pc_r;
               end
               inst_valid_r <= 1'b0;
               if (wb_ack_i) begin
                  // Latest redirect target, including one arriving with the ack.
                  adr_r   <= redirect_valid_in ? word_addr(redirect_pc_in) : word_addr(pc_r);
                  state_r <= FETCH;
               end else begin
                  state_r <= DISCARD;
               end
            end
            default: begin
               state_r      <= IDLE;
               cyc_r        <= 1'b0;
               inst_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign inst_valid_out = inst_valid_r;
   assign inst_out       = inst_r;
   assign pc_out         = pc_out_r;
   assign wb_cyc_o       = cyc_r;
   assign wb_stb_o       = cyc_r;
   assign wb_adr_o       = adr_r;
   assign wb_we_o        = 1'b0;
   assign wb_sel_o       = {(DATA_WIDTH/8){1'b1}};

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: Wishbone slave model with programmable
// ack latency, expected instructions and bus addresses kept in scoreboard queues.
module tb_if_fetch;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect_valid_in;
   logic [31:0] redirect_pc_in;
   logic        inst_valid_out;
   logic        inst_ready_in;
   logic [31:0] inst_out;
   logic [31:0] pc_out;
   logic        wb_cyc_o, wb_stb_o, wb_ack_i, wb_we_o;
   logic [31:0] wb_adr_o, wb_dat_i;
   logic [3:0]  wb_sel_o;

   int          tests_run = 0;
   int          tests_failed = 0;
   int          ack_delay = 1;
   int          slv_cnt = 0;
   logic [31:0] adr_log[$];
   exp_t        exp_q[$];
   exp_t        e;
   logic        to;
   logic [31:0] got;
   logic [31:0] exp_pc;
   int          hs;

   if_fetch dut (
      .clk(clk), .rst_n(rst_n),
      .redirect_valid_in(redirect_valid_in), .redirect_pc_in(redirect_pc_in),
      .inst_valid_out(inst_valid_out), .inst_ready_in(inst_ready_in),
      .inst_out(inst_out), .pc_out(pc_out),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i),
      .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h8000_0013;
   endfunction

   // Slave: acks after ack_delay cycles of stb, logs every acked address.
   initial begin
      wb_ack_i = 1'b0;
      wb_dat_i = 32'h0;
      forever begin
         @(negedge clk);
         if (wb_ack_i) begin
            wb_ack_i = 1'b0;
            slv_cnt  = 0;
         end
         if (rst_n && wb_cyc_o && wb_stb_o) begin
            slv_cnt++;
            if (slv_cnt >= ack_delay) begin
               wb_ack_i = 1'b1;
               wb_dat_i = mem_word(wb_adr_o);
               adr_log.push_back(wb_adr_o);
            end
         end else begin
            slv_cnt = 0;
         end
      end
   end

   task automatic wait_valid(input int max_cyc, output logic timed_out);
      timed_out = 1'b1;
      for (int i = 0; i < max_cyc; i++) begin
         if (inst_valid_out === 1'b1) begin
            timed_out = 1'b0;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic accept();
      inst_ready_in = 1'b1;
      @(negedge clk);
      inst_ready_in = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      tests_run++; if ({wb_cyc_o, wb_stb_o, inst_valid_out, wb_we_o} !== 4'b0000) begin tests_failed++; $display("FAIL reset_ctrl: got %b want 0000", {wb_cyc_o, wb_stb_o, inst_valid_out, wb_we_o}); end
      tests_run++; if ({wb_adr_o, pc_out, inst_out} !== 96'h0) begin tests_failed++; $display("FAIL reset_data: got %h %h %h want zeros", wb_adr_o, pc_out, inst_out); end
      tests_run++; if (wb_sel_o !== 4'hF) begin tests_failed++; $display("FAIL reset_sel: got %h want f", wb_sel_o); end
      exp_q.push_back('{pc: 32'h8000_0000, inst: 32'h0000_0013});
      rst_n = 1'b1;
      @(negedge clk);
      tests_run++; if ({wb_stb_o, wb_adr_o} !== {1'b1, 32'h8000_0000}) begin tests_failed++; $display("FAIL first_stb: got %b %h want 1 80000000", wb_stb_o, wb_adr_o); end
      wait_valid(10, to);
      tests_run++; if (to) begin tests_failed++; $display("FAIL first_valid: got timeout want valid"); end
      e = exp_q.pop_front();
      tests_run++; if ({pc_out, inst_out} !== {e.pc, e.inst}) begin tests_failed++; $display("FAIL first_inst: got %h %h want %h %h", pc_out, inst_out, e.pc, e.inst); end
      got = (adr_log.size() > 0) ? adr_log.pop_front() : 32'hxxxx_xxxx;
      tests_run++; if (got !== 32'h8000_0000) begin tests_failed++; $display("FAIL first_adr: got %h want 80000000", got); end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests_run++; if ({inst_valid_out, wb_cyc_o, pc_out, inst_out} !== {1'b1, 1'b0, 32'h8000_0000, 32'h0000_0013}) begin tests_failed++; $display("FAIL bp_stable: got %b %b %h %h want 1 0 80000000 00000013", inst_valid_out, wb_cyc_o, pc_out, inst_out); end
      end
      exp_q.push_back('{pc: 32'h8000_0004, inst: mem_word(32'h8000_0004)});
      accept();
      wait_valid(10, to);
      tests_run++; if (to) begin tests_failed++; $display("FAIL bp_valid: got timeout want valid"); end
      e = exp_q.pop_front();
      tests_run++; if ({pc_out, inst_out} !== {e.pc, e.inst}) begin tests_failed++; $display("FAIL bp_inst: got %h %h want %h %h", pc_out, inst_out, e.pc, e.inst); end
      got = (adr_log.size() > 0) ? adr_log.pop_front() : 32'hxxxx_xxxx;
      tests_run++; if (got !== 32'h8000_0004) begin tests_failed++; $display("FAIL bp_adr: got %h want 80000004", got); end
   endtask

   task automatic test_throughput();
      exp_pc = 32'h8000_0004;
      hs = 0;
      inst_ready_in = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (inst_valid_out === 1'b1) begin
            tests_run++; if ({pc_out, inst_out} !== {exp_pc, mem_word(exp_pc)}) begin tests_failed++; $display("FAIL tp_inst: got %h %h want %h %h", pc_out, inst_out, exp_pc, mem_word(exp_pc)); end
            exp_pc = exp_pc + 32'd4;
            hs++;
         end
         @(negedge clk);
      end
      inst_ready_in = 1'b0;
      tests_run++; if (hs < 4) begin tests_failed++; $display("FAIL tp_rate: got %0d want >=4 in 12 cycles", hs); end
      wait_valid(10, to);
      tests_run++; if (to || pc_out !== exp_pc) begin tests_failed++; $display("FAIL tp_last: got %h want %h", pc_out, exp_pc); end
      adr_log.delete();
   endtask

   task automatic test_redirect_discard();
      ack_delay = 3;
      exp_q.push_back('{pc: 32'h8000_0100, inst: mem_word(32'h8000_0100)});
      accept();
      redirect_valid_in = 1'b1;
      redirect_pc_in    = 32'h8000_0100;
      @(negedge clk);
      redirect_valid_in = 1'b0;
      tests_run++; if ({wb_stb_o, inst_valid_out, wb_adr_o} !== {1'b1, 1'b0, exp_pc + 32'd4}) begin tests_failed++; $display("FAIL disc_hold: got %b %b %h want 1 0 %h", wb_stb_o, inst_valid_out, wb_adr_o, exp_pc + 32'd4); end
      wait_valid(30, to);
      e = exp_q.pop_front();
      tests_run++; if (to || {pc_out, inst_out} !== {e.pc, e.inst}) begin tests_failed++; $display("FAIL disc_inst: got %h %h want %h %h", pc_out, inst_out, e.pc, e.inst); end
      got = (adr_log.size() > 0) ? adr_log.pop_front() : 32'hxxxx_xxxx;
      tests_run++; if (got !== exp_pc + 32'd4) begin tests_failed++; $display("FAIL disc_old_adr: got %h want %h", got, exp_pc + 32'd4); end
      got = (adr_log.size() > 0) ? adr_log.pop_front() : 32'hxxxx_xxxx;
      tests_run++; if (got !== 32'h8000_0100) begin tests_failed++; $display("FAIL disc_new_adr: got %h want 80000100", got); end
   endtask

   task automatic test_redirect_with_ack();
      ack_delay = 1;
      adr_log.delete();
      exp_q.push_back('{pc: 32'h8000_0300, inst: mem_word(32'h8000_0300)});
      accept();
      redirect_valid_in = 1'b1;
      redirect_pc_in    = 32'h8000_0300;
      @(negedge clk);
      redirect_valid_in = 1'b0;
      tests_run++; if ({wb_stb_o, inst_valid_out, wb_adr_o} !== {1'b1, 1'b0, 32'h8000_0300}) begin tests_failed++; $display("FAIL ackred_nodisc: got %b %b %h want 1 0 80000300", wb_stb_o, inst_valid_out, wb_adr_o); end
      wait_valid(10, to);
      e = exp_q.pop_front();
      tests_run++; if (to || {pc_out, inst_out} !== {e.pc, e.inst}) begin tests_failed++; $display("FAIL ackred_inst: got %h %h want %h %h", pc_out, inst_out, e.pc, e.inst); end
      got = (adr_log.size() > 0) ? adr_log.pop_front() : 32'hxxxx_xxxx;
      tests_run++; if (got !== 32'h8000_0104) begin tests_failed++; $display("FAIL ackred_old_adr: got %h want 80000104", got); end
   endtask

   task automatic test_double_redirect();
      ack_delay = 3;
      adr_log.delete();
      exp_q.push_back('{pc: 32'h8000_0200, inst: mem_word(32'h8000_0200)});
      accept();
      redirect_valid_in = 1'b1;
      redirect_pc_in    = 32'h8000_0100;
      @(negedge clk);
      redirect_pc_in    = 32'h8000_0200;
      tests_run++; if ({wb_stb_o, wb_adr_o} !== {1'b1, 32'h8000_0304}) begin tests_failed++; $display("FAIL dbl_disc: got %b %h want 1 80000304", wb_stb_o, wb_adr_o); end
      @(negedge clk);
      redirect_valid_in = 1'b0;
      wait_valid(30, to);
      e = exp_q.pop_front();
      tests_run++; if (to || {pc_out, inst_out} !== {e.pc, e.inst}) begin tests_failed++; $display("FAIL dbl_inst: got %h %h want %h %h", pc_out, inst_out, e.pc, e.inst); end
      got = (adr_log.size() > 1) ? adr_log[1] : 32'hxxxx_xxxx;
      tests_run++; if (got !== 32'h8000_0200) begin tests_failed++; $display("FAIL dbl_adr: got %h want 80000200", got); end
   endtask

   task automatic test_wrap_align();
      ack_delay = 1;
      adr_log.delete();
      exp_q.push_back('{pc: 32'hFFFF_FFFC, inst: mem_word(32'hFFFF_FFFC)});
      exp_q.push_back('{pc: 32'h0000_0000, inst: mem_word(32'h0000_0000)});
      exp_q.push_back('{pc: 32'h8000_0402, inst: mem_word(32'h8000_0400)});
      inst_ready_in     = 1'b1;
      redirect_valid_in = 1'b1;
      redirect_pc_in    = 32'hFFFF_FFFC;
      @(negedge clk);
      inst_ready_in     = 1'b0;
      redirect_valid_in = 1'b0;
      tests_run++; if ({inst_valid_out, wb_adr_o} !== {1'b0, 32'hFFFF_FFFC}) begin tests_failed++; $display("FAIL rdy_red: got %b %h want 0 fffffffc", inst_valid_out, wb_adr_o); end
      for (int k = 0; k < 2; k++) begin
         wait_valid(10, to);
         e = exp_q.pop_front();
         tests_run++; if (to || {pc_out, inst_out} !== {e.pc, e.inst}) begin tests_failed++; $display("FAIL wrap_inst: got %h %h want %h %h", pc_out, inst_out, e.pc, e.inst); end
         if (k == 0) accept();
      end
      redirect_valid_in = 1'b1;
      redirect_pc_in    = 32'h8000_0402;
      @(negedge clk);
      redirect_valid_in = 1'b0;
      tests_run++; if (wb_adr_o !== 32'h8000_0400) begin tests_failed++; $display("FAIL align_adr: got %h want 80000400", wb_adr_o); end
      wait_valid(10, to);
      e = exp_q.pop_front();
      tests_run++; if (to || {pc_out, inst_out} !== {e.pc, e.inst}) begin tests_failed++; $display("FAIL align_inst: got %h %h want %h %h", pc_out, inst_out, e.pc, e.inst); end
      got = (adr_log.size() > 1) ? adr_log[1] : 32'hxxxx_xxxx;
      tests_run++; if (got !== 32'h0000_0000) begin tests_failed++; $display("FAIL wrap_adr: got %h want 00000000", got); end
   endtask

   task automatic test_reset_mid_fetch();
      ack_delay = 3;
      accept();
      tests_run++; if ({wb_stb_o, wb_adr_o} !== {1'b1, 32'h8000_0404}) begin tests_failed++; $display("FAIL rmf_fetch: got %b %h want 1 80000404", wb_stb_o, wb_adr_o); end
      #2 rst_n = 1'b0;
      #1;
      tests_run++; if ({wb_cyc_o, wb_stb_o, inst_valid_out, wb_adr_o} !== 35'h0) begin tests_failed++; $display("FAIL rmf_drop: got %b %b %b %h want 0 0 0 0", wb_cyc_o, wb_stb_o, inst_valid_out, wb_adr_o); end
      @(negedge clk);
      @(negedge clk);
      ack_delay = 1;
      adr_log.delete();
      exp_q.push_back('{pc: 32'h8000_0000, inst: 32'h0000_0013});
      rst_n = 1'b1;
      wait_valid(10, to);
      e = exp_q.pop_front();
      tests_run++; if (to || {pc_out, inst_out} !== {e.pc, e.inst}) begin tests_failed++; $display("FAIL rmf_inst: got %h %h want %h %h", pc_out, inst_out, e.pc, e.inst); end
      got = (adr_log.size() > 0) ? adr_log.pop_front() : 32'hxxxx_xxxx;
      tests_run++; if (got !== 32'h8000_0000) begin tests_failed++; $display("FAIL rmf_adr: got %h want 80000000", got); end
   endtask

   // Watchdog: a stuck run still reports before stopping.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n             = 1'b0;
      redirect_valid_in = 1'b0;
      redirect_pc_in    = 32'h0;
      inst_ready_in     = 1'b0;
      test_reset();
      test_backpressure();
      test_throughput();
      test_redirect_discard();
      test_redirect_with_ack();
      test_double_redirect();
      test_wrap_align();
      test_reset_mid_fetch();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
